// File: rtl/div_pkg.sv
// Shared definitions for the repeated-subtraction divider: controller state
// encoding and the default operand width.
package div_pkg;

    localparam int DIV_W_DEFAULT = 16;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LDA  = 3'd1,
        ST_LDB  = 3'd2,
        ST_RUN  = 3'd3,
        ST_DONE = 3'd4
    } div_state_e;

endpackage

// File: rtl/div_datapath.sv
// Datapath for the repeated-subtraction divider. It holds the remainder (R),
// divisor (D) and quotient (Q) registers. It also provides the R>=D
// comparator, the D==0 detect and the subtractor.
// Optional build macro: DIV_ONE_FASTPATH_EN adds the D==1 status and the
// single-cycle Q<=R, R<=0 load.
module div_datapath
    import div_pkg::*;
#(
    parameter int W = DIV_W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] data_in,
    input  logic         load_r,   // R <= data_in
    input  logic         load_d,   // D <= data_in
    input  logic         clr_q,    // Q <= 0
    input  logic         step,     // R <= R - D, Q <= Q + 1
    input  logic         sat_q,    // Q <= all ones (divide by zero)
`ifdef DIV_ONE_FASTPATH_EN
    input  logic         fast,     // Q <= R, R <= 0 (divide by one)
    output logic         d_one,
`endif
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder,
    output logic         ge,
    output logic         dz
);

    logic [W-1:0] r_q, r_d;
    logic [W-1:0] d_q, d_d;
    logic [W-1:0] q_q, q_d;

    assign ge = (r_q >= d_q);
    assign dz = (d_q == '0);
`ifdef DIV_ONE_FASTPATH_EN
    assign d_one = (d_q == W'(1));
`endif

    assign quotient  = q_q;
    assign remainder = r_q;

    // Next-state selection for R, D and Q from the controller strobes.
    always_comb begin
        // NOTE: every combinational output gets a default first so that no
        // path through the block leaves it unassigned (which would infer a latch).
        r_d = r_q;
        d_d = d_q;
        q_d = q_q;
        if (load_r) r_d = data_in;
        if (load_d) d_d = data_in;
        if (clr_q)  q_d = '0;
        if (step) begin
            r_d = r_q - d_q;   // guarded by ge in the controller, never wraps
            q_d = q_q + W'(1);
        end
        if (sat_q) q_d = '1;
`ifdef DIV_ONE_FASTPATH_EN
        if (fast) begin
            q_d = r_q;
            r_d = '0;
        end
`endif
    end

    // Operand and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (!rst_n) begin
            r_q <= '0;
            d_q <= '0;
            q_q <= '0;
        end else begin
            r_q <= r_d;
            d_q <= d_d;
            q_q <= q_d;
        end
    end

endmodule

// File: rtl/rep_sub_divider.sv
// Iterative unsigned divider by repeated subtraction. The controller FSM
// loads the dividend and then the divisor over data_in. It subtracts once per
// cycle and holds the results in DONE until start is released.
// Optional build macro: DIV_ONE_FASTPATH_EN finishes a divide by one in a
// single RUN cycle.
module rep_sub_divider
    import div_pkg::*;
#(
    parameter int W = DIV_W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] data_in,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder,
    output logic         busy,
    output logic         done,
    output logic         div_by_zero
);

    div_state_e state_q, state_d;
    logic       dbz_q, dbz_d;

    logic load_r, load_d, clr_q, step, sat_q;
    logic ge, dz;
`ifdef DIV_ONE_FASTPATH_EN
    logic fast, d_one;
`endif

    div_datapath #(.W(W)) u_datapath (
        .clk       (clk),
        .rst_n     (rst_n),
        .data_in   (data_in),
        .load_r    (load_r),
        .load_d    (load_d),
        .clr_q     (clr_q),
        .step      (step),
        .sat_q     (sat_q),
`ifdef DIV_ONE_FASTPATH_EN
        .fast      (fast),
        .d_one     (d_one),
`endif
        .quotient  (quotient),
        .remainder (remainder),
        .ge        (ge),
        .dz        (dz)
    );

    assign busy        = (state_q == ST_LDA) || (state_q == ST_LDB) || (state_q == ST_RUN);
    assign done        = (state_q == ST_DONE);
    assign div_by_zero = done && dbz_q;

    // Controller next state and datapath strobes.
    always_comb begin
        state_d = state_q;
        dbz_d   = dbz_q;
        load_r  = 1'b0;
        load_d  = 1'b0;
        clr_q   = 1'b0;
        step    = 1'b0;
        sat_q   = 1'b0;
`ifdef DIV_ONE_FASTPATH_EN
        fast    = 1'b0;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_LDA;
            end
            ST_LDA: begin
                load_r  = 1'b1;
                clr_q   = 1'b1;
                dbz_d   = 1'b0;
                state_d = ST_LDB;
            end
            ST_LDB: begin
                load_d  = 1'b1;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (dz) begin
                    sat_q   = 1'b1;
                    dbz_d   = 1'b1;
                    state_d = ST_DONE;
`ifdef DIV_ONE_FASTPATH_EN
                end else if (d_one && !dbz_q) begin
                    fast    = 1'b1;
                    state_d = ST_DONE;
`endif
                end else if (ge) begin
                    step = 1'b1;
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                // Holding start keeps the result; a new run needs start low first.
                if (!start) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Controller state and divide-by-zero flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dbz_q   <= dbz_d;
        end
    end

endmodule
